blake2_msg_feeder: RTL and testbench
====================================

// Module: blake2_msg_feeder
// PURPOSE
//  Host-side driver of the blake2 core byte interface. Takes a command (kk, nn, empty) plus a byte stream of key then message.
//  Emits 64-byte blocks with idx, first/last flags and ll; zero-pads the key block and the final block.
//  Collects the streamed hash bytes back into an nn-byte output stream. Sits between the SoC/PIO byte FIFO and the blake2 core.
// PARAMETERS
//  BLOCK_BYTES  64  bytes per core block; idx 63 closes a block
//  IDX_W        7   core data_idx width (low 6 bits significant, MSB driven 0)
//  LL_W         128 core ll width
//  CNT_W        64  internal byte-count width, zero-extended onto core_ll_o
//  KN_W         7   kk/nn width (values 0..64)
// PORTS
//  clk            in   1      clock
//  nreset         in   1      reset
//  cmd_v_i        in   1      job start; accepted when cmd_ready_o
//  cmd_ready_o    out  1      high in IDLE only
//  cmd_kk_i       in   KN_W   key length, 0 = unkeyed
//  cmd_nn_i       in   KN_W   digest length, 1..64
//  cmd_empty_i    in   1      message has zero bytes
//  cmd_slow_i     in   1      request core slow output (2 cycles/byte)
//  in_v_i/in_ready_o  in/out 1  byte-stream handshake, transfer on v&ready
//  in_data_i      in   8      key bytes first (kk), then message bytes
//  in_last_i      in   1      final message byte (ignored on key bytes)
//  core_ready_i   in   1      core ready_v_o
//  core_data_v_o  out  1      core data_v_i
//  core_data_idx_o out IDX_W  byte index in block 0..63
//  core_data_o    out  8      byte to core
//  core_first_o/core_last_o out 1  block_first_i/block_last_i, valid with every byte of block
//  core_ll_o      out  LL_W   total bytes hashed, stable from last-block byte 0 until DONE
//  core_kk_o/core_nn_o out KN_W  registered job kk/nn
//  core_slow_o    out  1      registered job slow flag
//  core_h_v_i/core_h_i in 1/8 core hash valid/byte
//  out_v_o/out_data_o/out_last_o out 1/8/1  digest bytes, no backpressure; last on byte nn-1
//  busy_o         out  1      high outside IDLE
// BEHAVIOUR
//  Reset nreset, synchronous, active-low; clock clk. Reset (also mid-job): state IDLE, all *_v_o/flags/counters 0, cmd_ready_o 1.
//  FSM: IDLE -> KEY (kk>0) | MSG | PAD (kk=0&empty); KEY -> KEY_PAD after kk bytes; KEY_PAD -> MSG|DONE_WAIT at idx 63.
//   MSG -> PAD on in_last_i before idx 63; MSG at idx 63 -> DONE_WAIT if in_last_i else MSG (next block).
//   PAD -> DONE_WAIT at idx 63; DONE_WAIT -> COLLECT on first core_h_v_i; COLLECT -> IDLE after nn output bytes.
//  Byte issue: core_data_v_o only when core_ready_i; max 1 byte/cycle; in_ready_o = core_ready_i & state in {KEY,MSG}.
//   KEY_PAD/PAD emit 8'h00. idx increments per issued byte, wraps 63->0.
//  Flags: core_first_o=1 for every byte of the first block; core_last_o=1 for every byte of the final block.
//   Final block = block containing in_last_i byte, the pad block, or the key block when cmd_empty_i.
//  ll: count of message bytes accepted, + BLOCK_BYTES if kk>0; empty&kk=0 -> ll=0, one all-zero block, first=last=1.
//   Message length multiple of 64: in_last_i on idx 63 closes block with last=1; no extra pad block.
//  Collect: core raises h_v early; discard first 1 (slow=0) or 2 (slow=1) h_v cycles.
//   Then sample every cycle (slow=0) or 2nd cycle of each pair (slow=1). out_v_o 1 cycle after sample; nn bytes total.
//  Simultaneous cmd_v_i outside IDLE ignored. in_v_i in IDLE/PAD/KEY_PAD/DONE_WAIT stalls (in_ready_o=0).
// CONFIGURATION
//  BLAKE2_FEED_KEY_EN defined: keyed mode as above.
//  Undefined: cmd_kk_i ignored, core_kk_o=0, KEY/KEY_PAD states removed, first stream byte is message.
// STRUCTURE
//  Package blake2_feed_pkg: state enum, BLOCK_BYTES, IDX_W/KN_W/CNT_W constants.
//  Sub-module blake2_hash_collect: skip/decimate/count logic for h_v -> out stream.
// TESTING
//  kk=0,nn=32,"abc" (in_last on 'c') -> 1 block: bytes 61,62,63,then 61 zeros; first=last=1, ll=3, out 32 bytes with out_last on byte 31.
//  kk=0, 64-byte message -> exactly 64 issued bytes, no pad block, first=last=1, ll=64.
//  kk=0, 65 bytes -> block0 first=1,last=0; block1 byte 0x41th msg + 63 zeros, last=1, ll=65.
//  kk=16,nn=64,empty (BLAKE2_FEED_KEY_EN) -> 16 key bytes + 48 zeros, first=last=1, ll=64.
//  slow=1,nn=4 -> first 2 h_v cycles dropped, 4 out bytes each from 2nd cycle of pair, match core model.
//  Reset asserted mid-MSG at idx 20 -> next cycle IDLE, core_data_v_o=0; new "abc" job then hashes correctly.

Source files
------------

// File: rtl/blake2_feed_pkg.sv
// Shared constants, FSM encodings and the job descriptor for the blake2 message feeder.
// Pure declarations: no latency, no backpressure.
package blake2_feed_pkg;

  localparam int BLOCK_BYTES = 64;
  localparam int IDX_W       = 7;
  localparam int LL_W        = 128;
  localparam int CNT_W       = 64;
  localparam int KN_W        = 7;
  localparam int BI_W        = 6;

  localparam logic [BI_W-1:0] LAST_IDX = BI_W'(BLOCK_BYTES - 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_KEY       = 3'd1;
  localparam logic [2:0] ST_KEY_PAD   = 3'd2;
  localparam logic [2:0] ST_MSG       = 3'd3;
  localparam logic [2:0] ST_PAD       = 3'd4;
  localparam logic [2:0] ST_DONE_WAIT = 3'd5;
  localparam logic [2:0] ST_COLLECT   = 3'd6;

  typedef struct packed {
    logic [KN_W-1:0] kk;
    logic [KN_W-1:0] nn;
    logic            empty;
    logic            slow;
  } job_t;

endpackage

// File: rtl/blake2_hash_collect.sv
// Turns the core's early/decimated hash-valid strobes into a clean nn-byte digest stream.
// Latency: out_v_o one cycle after the sampled h_v cycle. Backpressure: none, output is fire-and-forget.
module blake2_hash_collect
  import blake2_feed_pkg::*;
(
  input  logic            clk,
  input  logic            nreset,
  input  logic            en_i,
  input  logic            slow_i,
  input  logic [KN_W-1:0] nn_i,
  input  logic            h_v_i,
  input  logic [7:0]      h_i,
  output logic            out_v_o,
  output logic [7:0]      out_data_o,
  output logic            out_last_o
);

  logic [1:0]      skip_q, skip_d;
  logic            phase_q, phase_d;
  logic [KN_W-1:0] cnt_q, cnt_d;
  logic            take;
  logic [1:0]      skip_n;
  logic            out_v_q;
  logic [7:0]      out_data_q;
  logic            out_last_q;

  // The core raises h_v before the digest is real: one junk cycle, or one junk pair in slow mode.
  assign skip_n = slow_i ? 2'd2 : 2'd1;

  always_comb begin
    skip_d  = skip_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    if (!en_i) begin
      skip_d  = '0;
      phase_d = 1'b0;
      cnt_d   = '0;
    end else if (h_v_i) begin
      if (skip_q != skip_n) begin
        skip_d = skip_q + 2'd1;
      end else if (cnt_q != nn_i) begin
        take    = !slow_i || phase_q;
        phase_d = slow_i && !phase_q;
        if (take) cnt_d = cnt_q + KN_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      skip_q     <= '0;
      phase_q    <= 1'b0;
      cnt_q      <= '0;
      out_v_q    <= 1'b0;
      out_data_q <= 8'h00;
      out_last_q <= 1'b0;
    end else begin
      skip_q     <= skip_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      out_v_q    <= take;
      out_last_q <= take && (cnt_q == nn_i - KN_W'(1));
      if (take) out_data_q <= h_i;
    end
  end

  assign out_v_o    = out_v_q;
  assign out_data_o = out_data_q;
  assign out_last_o = out_v_q && out_last_q;

endmodule

// File: rtl/blake2_msg_feeder.sv
// Splits a key+message byte stream into zero-padded 64-byte blake2 core blocks and gathers the digest; keyed mode under BLAKE2_FEED_KEY_EN.
// Latency: each block is buffered whole before issue so first/last/ll are known on byte 0; digest byte 1 cycle after sampling.
// Backpressure: in_ready_o follows core_ready_i and stalls while a buffered block drains; digest output cannot be stalled.
module blake2_msg_feeder
  import blake2_feed_pkg::*;
(
  input  logic             clk,
  input  logic             nreset,
  input  logic             cmd_v_i,
  output logic             cmd_ready_o,
  input  logic [KN_W-1:0]  cmd_kk_i,
  input  logic [KN_W-1:0]  cmd_nn_i,
  input  logic             cmd_empty_i,
  input  logic             cmd_slow_i,
  input  logic             in_v_i,
  output logic             in_ready_o,
  input  logic [7:0]       in_data_i,
  input  logic             in_last_i,
  input  logic             core_ready_i,
  output logic             core_data_v_o,
  output logic [IDX_W-1:0] core_data_idx_o,
  output logic [7:0]       core_data_o,
  output logic             core_first_o,
  output logic             core_last_o,
  output logic [LL_W-1:0]  core_ll_o,
  output logic [KN_W-1:0]  core_kk_o,
  output logic [KN_W-1:0]  core_nn_o,
  output logic             core_slow_o,
  input  logic             core_h_v_i,
  input  logic [7:0]       core_h_i,
  output logic             out_v_o,
  output logic [7:0]       out_data_o,
  output logic             out_last_o,
  output logic             busy_o
);

  logic [2:0]       state_q, state_d;
  job_t             job_q, job_d;
  logic [BI_W-1:0]  wr_idx_q, wr_idx_d;
  logic [BI_W-1:0]  rd_idx_q;
  logic [CNT_W-1:0] msg_cnt_q, msg_cnt_d;
  logic [CNT_W-1:0] ll_q;
  logic [CNT_W-1:0] key_off;
  logic             blk_first_q, blk_first_d;
  logic             emit_q, emit_first_q, emit_last_q;
  logic [7:0]       buf_q [BLOCK_BYTES];
  logic             wr_en;
  logic [7:0]       wr_dat;
  logic             launch, launch_last;
  logic             in_fire, cmd_fire, pad_state, collect_en;
  logic [KN_W-1:0]  cmd_kk_eff;

`ifdef BLAKE2_FEED_KEY_EN
  assign cmd_kk_eff = cmd_kk_i;
`else
  logic [KN_W-1:0] unused_kk;
  assign unused_kk  = cmd_kk_i;
  assign cmd_kk_eff = '0;
`endif

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign busy_o      = !cmd_ready_o;
  assign cmd_fire    = cmd_v_i && cmd_ready_o;
  assign in_ready_o  = core_ready_i && !emit_q && (state_q == ST_KEY || state_q == ST_MSG);
  assign in_fire     = in_v_i && in_ready_o;
  assign pad_state   = (state_q == ST_PAD) || (state_q == ST_KEY_PAD);
  assign key_off     = (job_q.kk != '0) ? CNT_W'(BLOCK_BYTES) : '0;

  // Assembly side: fills the block buffer; a block is launched to the core once its byte 63 is written.
  always_comb begin
    state_d     = state_q;
    job_d       = job_q;
    wr_idx_d    = wr_idx_q;
    msg_cnt_d   = msg_cnt_q;
    blk_first_d = blk_first_q;
    wr_en       = 1'b0;
    wr_dat      = pad_state ? 8'h00 : in_data_i;
    launch      = 1'b0;
    launch_last = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_v_i) begin
          job_d.kk    = cmd_kk_eff;
          job_d.nn    = cmd_nn_i;
          job_d.empty = cmd_empty_i;
          job_d.slow  = cmd_slow_i;
          wr_idx_d    = '0;
          msg_cnt_d   = '0;
          blk_first_d = 1'b1;
          if (cmd_kk_eff != '0) state_d = ST_KEY;
          else if (cmd_empty_i) state_d = ST_PAD;
          else state_d = ST_MSG;
        end
      end
`ifdef BLAKE2_FEED_KEY_EN
      ST_KEY: begin
        if (in_fire) begin
          wr_en    = 1'b1;
          wr_idx_d = wr_idx_q + BI_W'(1);
          if (wr_idx_q == BI_W'(job_q.kk - KN_W'(1))) begin
            if (wr_idx_q == LAST_IDX) begin
              launch      = 1'b1;
              launch_last = job_q.empty;
              state_d     = job_q.empty ? ST_DONE_WAIT : ST_MSG;
            end else begin
              state_d = ST_KEY_PAD;
            end
          end
        end
      end
      ST_KEY_PAD: begin
        if (!emit_q) begin
          wr_en    = 1'b1;
          wr_idx_d = wr_idx_q + BI_W'(1);
          if (wr_idx_q == LAST_IDX) begin
            launch      = 1'b1;
            launch_last = job_q.empty;
            state_d     = job_q.empty ? ST_DONE_WAIT : ST_MSG;
          end
        end
      end
`endif
      ST_MSG: begin
        if (in_fire) begin
          wr_en     = 1'b1;
          wr_idx_d  = wr_idx_q + BI_W'(1);
          msg_cnt_d = msg_cnt_q + CNT_W'(1);
          if (wr_idx_q == LAST_IDX) begin
            launch      = 1'b1;
            launch_last = in_last_i;
            state_d     = in_last_i ? ST_DONE_WAIT : ST_MSG;
          end else if (in_last_i) begin
            state_d = ST_PAD;
          end
        end
      end
      ST_PAD: begin
        if (!emit_q) begin
          wr_en    = 1'b1;
          wr_idx_d = wr_idx_q + BI_W'(1);
          if (wr_idx_q == LAST_IDX) begin
            launch      = 1'b1;
            launch_last = 1'b1;
            state_d     = ST_DONE_WAIT;
          end
        end
      end
      ST_DONE_WAIT: begin
        if (core_h_v_i) state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (out_v_o && out_last_o) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (launch) blk_first_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) buf_q[wr_idx_q] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q      <= ST_IDLE;
      job_q        <= '0;
      wr_idx_q     <= '0;
      msg_cnt_q    <= '0;
      blk_first_q  <= 1'b0;
      emit_q       <= 1'b0;
      rd_idx_q     <= '0;
      emit_first_q <= 1'b0;
      emit_last_q  <= 1'b0;
      ll_q         <= '0;
    end else begin
      state_q     <= state_d;
      job_q       <= job_d;
      wr_idx_q    <= wr_idx_d;
      msg_cnt_q   <= msg_cnt_d;
      blk_first_q <= blk_first_d;
      if (cmd_fire) begin
        ll_q <= '0;
      end else if (launch) begin
        ll_q <= msg_cnt_d + key_off;
      end
      // Issue side: drains the launched block one byte per ready cycle.
      if (launch) begin
        emit_q       <= 1'b1;
        rd_idx_q     <= '0;
        emit_first_q <= blk_first_q;
        emit_last_q  <= launch_last;
      end else if (emit_q && core_ready_i) begin
        rd_idx_q <= rd_idx_q + BI_W'(1);
        if (rd_idx_q == LAST_IDX) emit_q <= 1'b0;
      end
    end
  end

  assign core_data_v_o   = emit_q && core_ready_i;
  assign core_data_idx_o = {{(IDX_W-BI_W){1'b0}}, rd_idx_q};
  assign core_data_o     = emit_q ? buf_q[rd_idx_q] : 8'h00;
  assign core_first_o    = emit_q && emit_first_q;
  assign core_last_o     = emit_q && emit_last_q;
  assign core_ll_o       = {{(LL_W-CNT_W){1'b0}}, ll_q};
  assign core_kk_o       = job_q.kk;
  assign core_nn_o       = job_q.nn;
  assign core_slow_o     = job_q.slow;

  assign collect_en = (state_q == ST_DONE_WAIT) || (state_q == ST_COLLECT);

  blake2_hash_collect u_collect (
    .clk        (clk),
    .nreset     (nreset),
    .en_i       (collect_en),
    .slow_i     (job_q.slow),
    .nn_i       (job_q.nn),
    .h_v_i      (core_h_v_i),
    .h_i        (core_h_i),
    .out_v_o    (out_v_o),
    .out_data_o (out_data_o),
    .out_last_o (out_last_o)
  );

endmodule

// File: tb/tb_blake2_msg_feeder.sv
// Directed bench for blake2_msg_feeder: block framing, padding, flags, ll, digest collection and mid-job reset.
module tb_blake2_msg_feeder;
  import blake2_feed_pkg::*;

  logic             clk = 1'b0;
  logic             nreset;
  logic             cmd_v_i, cmd_ready_o, cmd_empty_i, cmd_slow_i;
  logic [KN_W-1:0]  cmd_kk_i, cmd_nn_i;
  logic             in_v_i, in_ready_o, in_last_i;
  logic [7:0]       in_data_i;
  logic             core_ready_i, core_data_v_o, core_first_o, core_last_o, core_slow_o;
  logic [IDX_W-1:0] core_data_idx_o;
  logic [7:0]       core_data_o;
  logic [LL_W-1:0]  core_ll_o;
  logic [KN_W-1:0]  core_kk_o, core_nn_o;
  logic             core_h_v_i;
  logic [7:0]       core_h_i;
  logic             out_v_o, out_last_o, busy_o;
  logic [7:0]       out_data_o;

  always #5 clk = ~clk;

  blake2_msg_feeder dut (
    .clk(clk), .nreset(nreset),
    .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o), .cmd_kk_i(cmd_kk_i), .cmd_nn_i(cmd_nn_i),
    .cmd_empty_i(cmd_empty_i), .cmd_slow_i(cmd_slow_i),
    .in_v_i(in_v_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i), .in_last_i(in_last_i),
    .core_ready_i(core_ready_i), .core_data_v_o(core_data_v_o), .core_data_idx_o(core_data_idx_o),
    .core_data_o(core_data_o), .core_first_o(core_first_o), .core_last_o(core_last_o),
    .core_ll_o(core_ll_o), .core_kk_o(core_kk_o), .core_nn_o(core_nn_o), .core_slow_o(core_slow_o),
    .core_h_v_i(core_h_v_i), .core_h_i(core_h_i),
    .out_v_o(out_v_o), .out_data_o(out_data_o), .out_last_o(out_last_o), .busy_o(busy_o)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]       cap_dat[$];
  logic [IDX_W-1:0] cap_idx[$];
  logic             cap_first[$];
  logic             cap_last[$];
  logic [LL_W-1:0]  cap_ll[$];
  logic [7:0]       o_dat[$];
  logic             o_last[$];

  always @(negedge clk) begin
    if (core_data_v_o) begin
      cap_dat.push_back(core_data_o);
      cap_idx.push_back(core_data_idx_o);
      cap_first.push_back(core_first_o);
      cap_last.push_back(core_last_o);
      cap_ll.push_back(core_ll_o);
    end
    if (out_v_o) begin
      o_dat.push_back(out_data_o);
      o_last.push_back(out_last_o);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int wd;
    wd = 0;
    in_v_i = 1'b1; in_data_i = d; in_last_i = l;
    while (!in_ready_o && wd < 3000) begin tick(); wd++; end
    if (wd >= 3000) chk("in_ready_timeout", 64'(in_ready_o), 64'd1);
    tick();
    in_v_i = 1'b0; in_last_i = 1'b0;
  endtask

  task automatic start_cmd(input int kk_pin, input int nn, input bit empty, input bit slow);
    cmd_v_i = 1'b1; cmd_kk_i = KN_W'(kk_pin); cmd_nn_i = KN_W'(nn);
    cmd_empty_i = empty; cmd_slow_i = slow;
    tick();
    cmd_v_i = 1'b0;
  endtask

  task automatic run_job(input string nm, input int kk_pin, input int nn, input int len,
                         input bit empty, input bit slow, input bit tog);
    int kk, nblk, nexp, wd, b, pos, m, ll_exp, lim;
    int bad_d, bad_i, bad_f, bad_l, bad_ll, bad_o, bad_ol;
    logic [7:0] ed;
`ifdef BLAKE2_FEED_KEY_EN
    kk = kk_pin;
`else
    kk = 0;
`endif
    nblk = (kk > 0 ? 1 : 0) + (empty ? 0 : (len + 63) / 64);
    if (nblk == 0) nblk = 1;
    nexp   = nblk * 64;
    ll_exp = (empty ? 0 : len) + (kk > 0 ? 64 : 0);
    cap_dat.delete(); cap_idx.delete(); cap_first.delete(); cap_last.delete(); cap_ll.delete();
    o_dat.delete(); o_last.delete();

    start_cmd(kk_pin, nn, empty, slow);
    chk({nm, "_kk"}, 64'(core_kk_o), 64'(kk));
    chk({nm, "_nn"}, 64'(core_nn_o), 64'(nn));
    chk({nm, "_slow"}, 64'(core_slow_o), 64'(slow));
    chk({nm, "_busy"}, 64'(busy_o), 64'd1);

    for (int i = 0; i < kk; i++) send_byte(8'(8'h10 + i), 1'b0);
    if (!empty) for (int i = 0; i < len; i++) send_byte(8'(8'h61 + i), i == len - 1);

    wd = 0;
    while (cap_dat.size() < nexp && wd < 3000) begin
      if (tog) core_ready_i = ~core_ready_i;
      tick();
      wd++;
    end
    core_ready_i = 1'b1;
    repeat (4) tick();
    chk({nm, "_nbytes"}, 64'(cap_dat.size()), 64'(nexp));

    bad_d = 0; bad_i = 0; bad_f = 0; bad_l = 0; bad_ll = 0;
    lim = (cap_dat.size() < nexp) ? cap_dat.size() : nexp;
    for (int j = 0; j < lim; j++) begin
      b = j / 64; pos = j % 64;
      if (kk > 0 && b == 0) ed = (pos < kk) ? 8'(8'h10 + pos) : 8'h00;
      else begin
        m  = (b - (kk > 0 ? 1 : 0)) * 64 + pos;
        ed = (!empty && m < len) ? 8'(8'h61 + m) : 8'h00;
      end
      if (cap_dat[j] !== ed) bad_d++;
      if (cap_idx[j] !== IDX_W'(pos)) bad_i++;
      if (cap_first[j] !== (b == 0)) bad_f++;
      if (cap_last[j] !== (b == nblk - 1)) bad_l++;
      if (b == nblk - 1 && cap_ll[j] !== LL_W'(ll_exp)) bad_ll++;
    end
    chk({nm, "_data_bad"}, 64'(bad_d), 64'd0);
    chk({nm, "_idx_bad"}, 64'(bad_i), 64'd0);
    chk({nm, "_first_bad"}, 64'(bad_f), 64'd0);
    chk({nm, "_last_bad"}, 64'(bad_l), 64'd0);
    chk({nm, "_ll_bad"}, 64'(bad_ll), 64'd0);

    // Core model: junk h_v cycle(s) first, then digest bytes C0+i (slow: junk/real pairs).
    core_h_v_i = 1'b1; core_h_i = 8'hEE;
    tick();
    if (slow) tick();
    for (int i = 0; i < nn; i++) begin
      if (slow) begin core_h_i = 8'hEE; tick(); end
      core_h_i = 8'(8'hC0 + i);
      tick();
    end
    core_h_v_i = 1'b0; core_h_i = 8'h00;
    wd = 0;
    while (!cmd_ready_o && wd < 50) begin tick(); wd++; end
    repeat (2) tick();
    chk({nm, "_idle_after"}, 64'(cmd_ready_o), 64'd1);
    chk({nm, "_out_cnt"}, 64'(o_dat.size()), 64'(nn));
    bad_o = 0; bad_ol = 0;
    for (int i = 0; i < o_dat.size(); i++) begin
      if (o_dat[i] !== 8'(8'hC0 + i)) bad_o++;
      if (o_last[i] !== (i == nn - 1)) bad_ol++;
    end
    chk({nm, "_out_bad"}, 64'(bad_o), 64'd0);
    chk({nm, "_out_last_bad"}, 64'(bad_ol), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    nreset = 1'b0; cmd_v_i = 1'b0; cmd_kk_i = '0; cmd_nn_i = '0; cmd_empty_i = 1'b0; cmd_slow_i = 1'b0;
    in_v_i = 1'b0; in_data_i = 8'h00; in_last_i = 1'b0; core_ready_i = 1'b1;
    core_h_v_i = 1'b0; core_h_i = 8'h00;
    repeat (2) tick();
    chk("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_in_ready", 64'(in_ready_o), 64'd0);
    chk("rst_data_v", 64'(core_data_v_o), 64'd0);
    chk("rst_first_last", 64'({core_first_o, core_last_o}), 64'd0);
    chk("rst_ll", core_ll_o[63:0] | core_ll_o[127:64], 64'd0);
    chk("rst_out_v", 64'(out_v_o), 64'd0);
    nreset = 1'b1;
    tick();

    run_job("abc", 0, 32, 3, 1'b0, 1'b0, 1'b0);
    run_job("len64", 0, 16, 64, 1'b0, 1'b0, 1'b0);
    run_job("len65", 0, 8, 65, 1'b0, 1'b0, 1'b1);
    run_job("slow", 0, 4, 3, 1'b0, 1'b1, 1'b0);
    run_job("empty0", 0, 8, 0, 1'b1, 1'b0, 1'b0);
`ifdef BLAKE2_FEED_KEY_EN
    run_job("key16", 16, 64, 0, 1'b1, 1'b0, 1'b0);
`else
    run_job("kk_ignored", 16, 8, 3, 1'b0, 1'b0, 1'b0);
`endif

    // Abort a 40-byte job after 20 bytes and confirm a clean restart.
    start_cmd(0, 16, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) send_byte(8'(8'h61 + i), 1'b0);
    chk("mid_busy", 64'(busy_o), 64'd1);
    nreset = 1'b0;
    tick();
    chk("mid_rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
    chk("mid_rst_busy", 64'(busy_o), 64'd0);
    chk("mid_rst_data_v", 64'(core_data_v_o), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready_o), 64'd0);
    nreset = 1'b1;
    tick();
    run_job("abc_after_rst", 0, 32, 3, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
